alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU for the datapath execute stage. It supersedes the fixed 32-bit, single-cycle ALU. It keeps the existing 3-bit operation encodings and adds XOR/NOR, unsigned compare, shifts, signed overflow, and iterative unsigned multiply/divide. A start/busy/done handshake lets the control unit stall the pipeline while a multi-cycle operation runs.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 84 ++++++++
 rtl/alu_multicycle.sv | 179 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multi-cycle ALU: 4-bit opcode encodings,
// FSM state type, iterative-unit mode type and the signed-overflow helper.
// No ports; imported by alu_multicycle and alu_muldiv_iter.
package alu_pkg;

  // The low 3-bit codes match the legacy single-cycle ALU; the new ops fill
  // the remaining space.
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } muldiv_mode_t;

  // Signed overflow from sign bits only, so it works for any WIDTH.
  // For subtraction the operands must have differing signs to overflow.
  function automatic logic signed_overflow(input logic a_sign,
                                           input logic b_sign,
                                           input logic r_sign,
                                           input logic is_sub);
    logic signs_ok;
    signs_ok = is_sub ? (a_sign != b_sign) : (a_sign == b_sign);
    return signs_ok && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit
// per step, sharing a single 2*WIDTH accumulator and the iteration counter.
// Ports:
//   clk, reset   clock, async active-high reset
//   load         capture a/b/mode and clear the counter
//   mode         MODE_MUL or MODE_DIV (sampled on load)
//   step         perform one iteration
//   a, b         operands (multiplicand/multiplier, dividend/divisor)
//   hi, lo       accumulator halves: product {hi,lo} or {remainder,quotient}
//   count        iterations performed since load
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  muldiv_mode_t       mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [CNT_W-1:0]   count
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  muldiv_mode_t       mode_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: the multiplier sits in the low half and is consumed LSB first;
  // the partial product accumulates in the high half and the whole thing
  // shifts right, carry included, so after WIDTH steps acc holds the product.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: shift {remainder, dividend} left by one and try to subtract the
  // divisor from the widened remainder. The trial is WIDTH+1 bits so its MSB
  // is a valid borrow; on success keep the difference and shift in a 1.
  always_comb begin
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      operand <= '0;
      mode_q  <= MODE_MUL;
      count   <= '0;
    end else if (load) begin
      mode_q <= mode;
      count  <= '0;
      if (mode == MODE_DIV) begin
        acc     <= {{WIDTH{1'b0}}, a};
        operand <= b;
      end else begin
        acc     <= {{WIDTH{1'b0}}, b};
        operand <= a;
      end
    end else if (step) begin
      acc   <= (mode_q == MODE_DIV) ? div_next : mul_next;
      count <= count + 1'b1;
    end
  end

  assign hi = acc[2*WIDTH-1:WIDTH];
  assign lo = acc[WIDTH-1:0];

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Execute-stage ALU with single-cycle logic/arith/shift ops and iterative
// unsigned multiply/divide behind a start/busy/done handshake.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               operation request, ignored while busy
//   op                  4-bit opcode (alu_pkg OP_*), unknown codes act as ADD
//   a, b                operands; b[$clog2(WIDTH)-1:0] is the shift amount
//   busy                iterative op in progress
//   done                one-cycle pulse when the result registers update
//   result, result_hi   low result / high product or remainder
//   zero, overflow      result==0, signed ADD/SUB overflow
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               overflow
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             is_iter;
  logic             div_by_zero;
  muldiv_mode_t     mode;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;
  logic [CNT_W-1:0] iter_count;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign is_iter     = (op == OP_MULTU) || (op == OP_DIVU);
  assign div_by_zero = (op == OP_DIVU) && (b == '0);
  assign mode        = (op == OP_DIVU) ? MODE_DIV : MODE_MUL;
  assign shamt       = b[SH_W-1:0];
  assign sum         = a + b;
  assign diff        = a - b;

  // Single-cycle result. The default arm is ADD, which also covers every
  // unassigned opcode.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = signed_overflow(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: begin
        alu_res = sum;
        alu_ovf = signed_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only a MULTU/DIVU with a usable divisor leaves IDLE; the RUN exit is
  // taken on the step that completes the WIDTH-th iteration.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_iter && !div_by_zero) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (iter_count == LAST_ITER) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers. busy covers RUN and FINISH, so it drops on the same
  // edge that raises done and the two are never high together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (load) begin
              busy <= 1'b1;
            end else if (div_by_zero) begin
              result    <= '1;
              result_hi <= a;
              zero      <= 1'b0;
              overflow  <= 1'b0;
              done      <= 1'b1;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              done      <= 1'b1;
            end
          end
        end
        FINISH: begin
          result    <= iter_lo;
          result_hi <= iter_hi;
          zero      <= (iter_lo == '0);
          overflow  <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .mode  (mode),
    .step  (step),
    .a     (a),
    .b     (b),
    .hi    (iter_hi),
    .lo    (iter_lo),
    .count (iter_count)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
// Directed self-checking bench: a 32-bit instance runs the main vector set,
// a 16-bit instance repeats the key cases at the smaller width.
module tb_alu_multicycle;

  localparam logic [3:0] T_AND   = 4'b0000;
  localparam logic [3:0] T_OR    = 4'b0001;
  localparam logic [3:0] T_ADD   = 4'b0010;
  localparam logic [3:0] T_XOR   = 4'b0011;
  localparam logic [3:0] T_NOR   = 4'b0100;
  localparam logic [3:0] T_SLTU  = 4'b0101;
  localparam logic [3:0] T_SUB   = 4'b0110;
  localparam logic [3:0] T_SLT   = 4'b0111;
  localparam logic [3:0] T_SLL   = 4'b1000;
  localparam logic [3:0] T_SRL   = 4'b1001;
  localparam logic [3:0] T_SRA   = 4'b1010;
  localparam logic [3:0] T_MULTU = 4'b1100;
  localparam logic [3:0] T_DIVU  = 4'b1101;

  logic        clk;
  logic        reset;

  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] result16;
  logic [15:0] result_hi16;
  logic        zero16;
  logic        overflow16;

  int checks = 0;
  int errors = 0;
  int busyCycles;
  int doneCount;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .start     (start16),
    .op        (op16),
    .a         (a16),
    .b         (b16),
    .busy      (busy16),
    .done      (done16),
    .result    (result16),
    .result_hi (result_hi16),
    .zero      (zero16),
    .overflow  (overflow16)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports one observed/expected pair.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkResult(input bit sel16, input string tag,
                             input logic [31:0] expLo, input logic [31:0] expHi,
                             input logic expZero, input logic expOvf);
    checkOutput({tag, ".result"},    sel16 ? {48'b0, result16}    : {32'b0, result},    {32'b0, expLo});
    checkOutput({tag, ".result_hi"}, sel16 ? {48'b0, result_hi16} : {32'b0, result_hi}, {32'b0, expHi});
    checkOutput({tag, ".zero"},      sel16 ? zero16 : zero,         {63'b0, expZero});
    checkOutput({tag, ".overflow"},  sel16 ? overflow16 : overflow, {63'b0, expOvf});
  endtask

  // Called at a falling edge; holds start for one rising edge, then scrambles
  // the operands to show they were captured at the start edge.
  task automatic applyStimulus(input bit sel16, input logic [3:0] o,
                               input logic [31:0] x, input logic [31:0] y);
    if (sel16) begin
      start16 = 1'b1; op16 = o; a16 = x[15:0]; b16 = y[15:0];
    end else begin
      start = 1'b1; op = o; a = x; b = y;
    end
    @(negedge clk);
    start = 1'b0; start16 = 1'b0;
    a = $urandom; b = $urandom;
    a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  // Waits for done, counting busy cycles. pokeAt>0 pulses a competing start
  // at that busy cycle, which the DUT must ignore.
  task automatic waitDone(input bit sel16, input int pokeAt, output int bc);
    int guard;
    bc = 0;
    guard = 0;
    while ((sel16 ? done16 : done) !== 1'b1 && guard < 200) begin
      if (sel16 ? busy16 : busy) bc++;
      if (pokeAt > 0 && bc == pokeAt) begin
        start = 1'b1; op = T_ADD; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if ((sel16 ? done16 : done) !== 1'b1) checkOutput("done_timeout", 64'd0, 64'd1);
    checkOutput("busy_with_done", {63'b0, (sel16 ? busy16 : busy)}, 64'd0);
  endtask

  task automatic runSingle(input string tag, input logic [3:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] expLo, input logic expZero,
                           input logic expOvf);
    applyStimulus(1'b0, o, x, y);
    checkOutput({tag, ".done"}, {63'b0, done}, 64'd1);
    waitDone(1'b0, 0, busyCycles);
    checkResult(1'b0, tag, expLo, 32'd0, expZero, expOvf);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    start = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst.busy", {63'b0, busy}, 64'd0);
    checkOutput("rst.done", {63'b0, done}, 64'd0);
    checkResult(1'b0, "rst", 32'd0, 32'd0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    runSingle("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("done_pulse_single", {63'b0, done}, 64'd0);

    // SUB then SLT issued in the cycle where the SUB's done is high.
    applyStimulus(1'b0, T_SUB, 32'd5, 32'd5);
    checkOutput("sub.done", {63'b0, done}, 64'd1);
    checkResult(1'b0, "sub_eq", 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, T_SLT, 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt.done", {63'b0, done}, 64'd1);
    checkResult(1'b0, "slt", 32'd1, 32'd0, 1'b0, 1'b0);
    @(negedge clk);

    runSingle("sltu",    T_SLTU,  32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1, 1'b0);
    runSingle("sra",     T_SRA,   32'h8000_0000, 32'h24,       32'hF800_0000, 1'b0, 1'b0);
    runSingle("sll",     T_SLL,   32'd1,         32'd31,       32'h8000_0000, 1'b0, 1'b0);
    runSingle("srl",     T_SRL,   32'h8000_0000, 32'hFF,       32'd1,         1'b0, 1'b0);
    runSingle("xor",     T_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0);
    runSingle("nor",     T_NOR,   32'd0,         32'd0,        32'hFFFF_FFFF, 1'b0, 1'b0);
    runSingle("and",     T_AND,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
    runSingle("or",      T_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0);
    runSingle("sub_ovf", T_SUB,   32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b0, 1'b1);
    runSingle("undef",   4'b1111, 32'd2,         32'd3,        32'd5,         1'b0, 1'b0);

    // MULTU with a competing start mid-run.
    applyStimulus(1'b0, T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(1'b0, 10, busyCycles);
    checkOutput("multu.busy_cycles", busyCycles, 64'd33);
    checkResult(1'b0, "multu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("multu.done_pulse", {63'b0, done}, 64'd0);
    checkOutput("multu.idle_busy", {63'b0, busy}, 64'd0);

    runSingle("add_after_mul", T_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);

    applyStimulus(1'b0, T_DIVU, 32'd100, 32'd7);
    waitDone(1'b0, 0, busyCycles);
    checkOutput("divu.busy_cycles", busyCycles, 64'd33);
    checkResult(1'b0, "divu", 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);

    // Abort a MULTU with reset during its 10th busy cycle.
    applyStimulus(1'b0, T_MULTU, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort.busy", {63'b0, busy}, 64'd0);
    checkOutput("abort.done", {63'b0, done}, 64'd0);
    checkResult(1'b0, "abort", 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort.no_done", doneCount, 64'd0);
    checkOutput("abort.idle_busy", {63'b0, busy}, 64'd0);

    runSingle("add_after_abort", T_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0);

    applyStimulus(1'b0, T_DIVU, 32'd9, 32'd0);
    checkOutput("div0.done", {63'b0, done}, 64'd1);
    waitDone(1'b0, 0, busyCycles);
    checkOutput("div0.busy_cycles", busyCycles, 64'd0);
    checkResult(1'b0, "div0", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0);
    @(negedge clk);

    // 16-bit instance.
    checkResult(1'b1, "w16.rst", 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, T_ADD, 32'h7FFF, 32'h1);
    checkOutput("w16.add.done", {63'b0, done16}, 64'd1);
    checkResult(1'b1, "w16.add_ovf", 32'h8000, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, T_SRA, 32'h8000, 32'h14);
    checkResult(1'b1, "w16.sra", 32'hF800, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, T_MULTU, 32'hFFFF, 32'hFFFF);
    waitDone(1'b1, 0, busyCycles);
    checkOutput("w16.multu.busy_cycles", busyCycles, 64'd17);
    checkResult(1'b1, "w16.multu", 32'h0001, 32'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, T_DIVU, 32'd100, 32'd7);
    waitDone(1'b1, 0, busyCycles);
    checkOutput("w16.divu.busy_cycles", busyCycles, 64'd17);
    checkResult(1'b1, "w16.divu", 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, T_DIVU, 32'd9, 32'd0);
    checkResult(1'b1, "w16.div0", 32'hFFFF, 32'd9, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
